// File: rtl/umix_pkg.sv
// rtl/umix_pkg.sv - shared UM-32 widths, register count and register-port mode encoding
package umix_pkg;

    localparam int WORD_W    = 32;
    localparam int REG_IDX_W = 3;
    localparam int NUM_REGS  = 8;

    typedef enum logic {
        REG_READ  = 1'b0,
        REG_WRITE = 1'b1
    } reg_mode_t;

endpackage

// File: rtl/umix_reg_unit.sv
// rtl/umix_reg_unit.sv - UM-32 general register file with registered read bus held through writes
module umix_reg_unit
    import umix_pkg::*;
#(
    parameter int NREGS = NUM_REGS,
    parameter int WIDTH = WORD_W,
    localparam int SEL_W = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             clk,
    input  logic             r,
    input  logic [SEL_W-1:0] reg_sel,
    input  logic             reg_s,
    input  logic [WIDTH-1:0] reg_in_bus,
    output logic [WIDTH-1:0] reg_out_bus,
    output logic             reg_out_zero,
    input  logic [SEL_W-1:0] dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);

    logic [WIDTH-1:0] r_regs [NREGS];
    logic [WIDTH-1:0] r_out_bus;
    logic             r_out_zero;

    reg_mode_t        w_mode;
    logic             w_sel_ok;
    logic             w_dbg_ok;
    logic [WIDTH-1:0] w_rd_data;

    assign w_mode   = reg_mode_t'(reg_s);
    assign w_sel_ok = int'(reg_sel) < NREGS;
    assign w_dbg_ok = int'(dbg_sel) < NREGS;

    // Indices beyond NREGS read as zero; unreachable when NREGS is a power of two.
    assign w_rd_data = w_sel_ok ? r_regs[reg_sel] : '0;
    assign dbg_data  = w_dbg_ok ? r_regs[dbg_sel] : '0;

    always_ff @(posedge clk) begin
        if (r) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_mode == REG_WRITE && w_sel_ok) begin
            r_regs[reg_sel] <= reg_in_bus;
        end
    end

    // Output bus only moves on reads so a client can feed it back as write data.
    always_ff @(posedge clk) begin
        if (r) begin
            r_out_bus  <= '0;
            r_out_zero <= 1'b1;
        end else if (w_mode == REG_READ) begin
            r_out_bus  <= w_rd_data;
            r_out_zero <= (w_rd_data == '0);
        end
    end

    assign reg_out_bus  = r_out_bus;
    assign reg_out_zero = r_out_zero;

endmodule

// File: tb/tb_umix_reg_unit.sv
// tb/tb_umix_reg_unit.sv - directed self-checking bench for umix_reg_unit
module tb_umix_reg_unit;

    logic        clk;
    logic        r;
    logic [2:0]  reg_sel;
    logic        reg_s;
    logic [31:0] reg_in_bus;
    logic [31:0] reg_out_bus;
    logic        reg_out_zero;
    logic [2:0]  dbg_sel;
    logic [31:0] dbg_data;

    int n_pass;
    int n_total;

    umix_reg_unit dut (
        .clk          (clk),
        .r            (r),
        .reg_sel      (reg_sel),
        .reg_s        (reg_s),
        .reg_in_bus   (reg_in_bus),
        .reg_out_bus  (reg_out_bus),
        .reg_out_zero (reg_out_zero),
        .dbg_sel      (dbg_sel),
        .dbg_data     (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] sel, input logic [31:0] val);
        reg_s      = 1'b1;
        reg_sel    = sel;
        reg_in_bus = val;
        cyc();
    endtask

    task automatic do_read(input logic [2:0] sel);
        reg_s      = 1'b0;
        reg_sel    = sel;
        reg_in_bus = 32'h0;
        cyc();
    endtask

    task automatic peek(input logic [2:0] sel, output logic [31:0] val);
        dbg_sel = sel;
        #1;
        val = dbg_data;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        r          = 1'b1;
        reg_s      = 1'b1;
        reg_sel    = 3'd4;
        reg_in_bus = 32'hFFFF_FFFF;
        cyc();
        r = 1'b0;
        n_total++;
        if (reg_out_bus !== 32'h0) $display("FAIL reset_out got %h want %h", reg_out_bus, 32'h0);
        else n_pass++;
        n_total++;
        if (reg_out_zero !== 1'b1) $display("FAIL reset_zero got %b want 1", reg_out_zero);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            peek(3'(i), v);
            n_total++;
            if (v !== 32'h0) $display("FAIL reset_reg%0d got %h want %h", i, v, 32'h0);
            else n_pass++;
        end
    endtask

    task automatic test_write_readback();
        logic [31:0] v;
        do_write(3'd3, 32'hDEAD_BEEF);
        peek(3'd3, v);
        n_total++;
        if (v !== 32'hDEAD_BEEF) $display("FAIL wr_dbg got %h want %h", v, 32'hDEAD_BEEF);
        else n_pass++;
        n_total++;
        if (reg_out_bus !== 32'h0) $display("FAIL wr_hold_out got %h want %h", reg_out_bus, 32'h0);
        else n_pass++;
        do_read(3'd3);
        n_total++;
        if (reg_out_bus !== 32'hDEAD_BEEF) $display("FAIL rd_out got %h want %h", reg_out_bus, 32'hDEAD_BEEF);
        else n_pass++;
        n_total++;
        if (reg_out_zero !== 1'b0) $display("FAIL rd_zero got %b want 0", reg_out_zero);
        else n_pass++;
    endtask

    task automatic test_hold_through_write();
        logic [31:0] v;
        do_write(3'd5, 32'h1234_5678);
        do_read(3'd5);
        n_total++;
        if (reg_out_bus !== 32'h1234_5678) $display("FAIL hold_rd got %h want %h", reg_out_bus, 32'h1234_5678);
        else n_pass++;
        reg_s      = 1'b1;
        reg_sel    = 3'd2;
        reg_in_bus = reg_out_bus;
        #3;
        n_total++;
        if (reg_out_bus !== 32'h1234_5678) $display("FAIL hold_during got %h want %h", reg_out_bus, 32'h1234_5678);
        else n_pass++;
        cyc();
        n_total++;
        if (reg_out_bus !== 32'h1234_5678) $display("FAIL hold_after got %h want %h", reg_out_bus, 32'h1234_5678);
        else n_pass++;
        n_total++;
        if (reg_out_zero !== 1'b0) $display("FAIL hold_zero got %b want 0", reg_out_zero);
        else n_pass++;
        peek(3'd2, v);
        n_total++;
        if (v !== 32'h1234_5678) $display("FAIL hold_r2 got %h want %h", v, 32'h1234_5678);
        else n_pass++;
    endtask

    task automatic cmov_run(input logic [31:0] c, input logic [31:0] want_r1, input string tag);
        logic [31:0] v;
        logic        cz;
        do_write(3'd1, 32'h7);
        do_write(3'd2, 32'hAB);
        do_write(3'd0, c);
        do_read(3'd0);
        cz = reg_out_zero;
        n_total++;
        if (cz !== (c == 32'h0)) $display("FAIL %s_czero got %b want %b", tag, cz, (c == 32'h0));
        else n_pass++;
        do_read(3'd2);
        n_total++;
        if (reg_out_bus !== 32'hAB) $display("FAIL %s_b got %h want %h", tag, reg_out_bus, 32'hAB);
        else n_pass++;
        if (cz) do_read(3'd0);
        else begin
            reg_s      = 1'b1;
            reg_sel    = 3'd1;
            reg_in_bus = reg_out_bus;
            cyc();
        end
        peek(3'd1, v);
        n_total++;
        if (v !== want_r1) $display("FAIL %s_r1 got %h want %h", tag, v, want_r1);
        else n_pass++;
    endtask

    task automatic test_cmov();
        logic [31:0] v;
        cmov_run(32'h0, 32'h7, "cmov0");
        cmov_run(32'h1, 32'hAB, "cmov1");
        do_write(3'd4, 32'h0BAD_F00D);
        do_read(3'd4);
        reg_s      = 1'b1;
        reg_sel    = 3'd4;
        reg_in_bus = reg_out_bus;
        cyc();
        peek(3'd4, v);
        n_total++;
        if (v !== 32'h0BAD_F00D) $display("FAIL cmov_self got %h want %h", v, 32'h0BAD_F00D);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] want;
        for (int i = 0; i < 8; i++) begin
            do_write(3'(i), 32'(i) * 32'h1111_1111);
        end
        for (int i = 0; i < 8; i++) begin
            do_read(3'(i));
            want = 32'(i) * 32'h1111_1111;
            n_total++;
            if (reg_out_bus !== want) $display("FAIL b2b_r%0d got %h want %h", i, reg_out_bus, want);
            else n_pass++;
            n_total++;
            if (reg_out_zero !== (i == 0)) $display("FAIL b2b_zero%0d got %b want %b", i, reg_out_zero, (i == 0));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] v;
        do_read(3'd7);
        r = 1'b1;
        do_write(3'd6, 32'hFFFF_FFFF);
        r = 1'b0;
        peek(3'd6, v);
        n_total++;
        if (v !== 32'h0) $display("FAIL rstw_r6 got %h want %h", v, 32'h0);
        else n_pass++;
        peek(3'd7, v);
        n_total++;
        if (v !== 32'h0) $display("FAIL rstw_r7 got %h want %h", v, 32'h0);
        else n_pass++;
        n_total++;
        if (reg_out_bus !== 32'h0) $display("FAIL rstw_out got %h want %h", reg_out_bus, 32'h0);
        else n_pass++;
        n_total++;
        if (reg_out_zero !== 1'b1) $display("FAIL rstw_zero got %b want 1", reg_out_zero);
        else n_pass++;
        do_write(3'd6, 32'h0000_0005);
        do_read(3'd6);
        n_total++;
        if (reg_out_bus !== 32'h5) $display("FAIL rstw_resume got %h want %h", reg_out_bus, 32'h5);
        else n_pass++;
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        r          = 1'b1;
        reg_sel    = 3'd0;
        reg_s      = 1'b0;
        reg_in_bus = 32'h0;
        dbg_sel    = 3'd0;
        test_reset();
        test_write_readback();
        test_hold_through_write();
        test_cmov();
        test_back_to_back();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
